dmem_arbiter: RTL and testbench

- Shares the single-port synchronous data memory between the onc_16 CPU and a host/debug port (loader, monitor, DMA).
- The CPU owns the bus by default.
- A host access stalls the CPU through its `en` input, performs one memory transaction, then returns ownership to the CPU.
- A guard counter enforces a minimum number of CPU cycles between host accesses.
- Sits between onc_16 (dmem_* ports) and the data RAM, which has 1-cycle read latency.

---
 rtl/dmem_arbiter_pkg.sv | 19 +
 rtl/dmem_arbiter.sv | 123 ++++++++++++
 tb/tb_dmem_arbiter.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the onc_16 data-memory arbiter: FSM state encoding
// and the guard-counter width helper.
package dmem_arbiter_pkg;

  localparam int ARB_ST_W = 2;

  typedef enum logic [ARB_ST_W-1:0] {
    S_CPU   = 2'd0,
    S_DRAIN = 2'd1,
    S_HOST  = 2'd2,
    S_RESP  = 2'd3
  } arb_state_t;

  // A zero-width counter is illegal, so GUARD=0 still gets one (always-zero) bit.
  function automatic int guard_width(input int guard);
    return (guard > 0) ? $clog2(guard + 1) : 1;
  endfunction

endpackage

// File: rtl/dmem_arbiter.sv
// Arbitrates the single-port data RAM between the onc_16 CPU (default owner)
// and a host/debug port that stalls the CPU for one transaction at a time.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int GUARD  = 4
) (
  input  logic              clock,
  input  logic              n_rst,
  input  logic              run_en,
  output logic              cpu_en,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic              cpu_we,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_gnt,
  output logic              host_rvalid,
  output logic [DATA_W-1:0] host_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int GW = guard_width(GUARD);
  localparam logic [GW-1:0] GUARD_LOAD = GW'(GUARD);

  arb_state_t        state;
  logic [GW-1:0]     guard_cnt;
  logic              hold_valid;
  logic [DATA_W-1:0] hold_q;
  logic              host_we_q;
  logic [ADDR_W-1:0] host_addr_q;
  logic [DATA_W-1:0] host_wdata_q;

  // The CPU's last read returns during S_DRAIN; park it so the CPU sees it on resume.
  assign cpu_rdata = hold_valid ? hold_q : mem_rdata;

  always_ff @(posedge clock or negedge n_rst) begin
    if (!n_rst) begin
      state        <= S_CPU;
      guard_cnt    <= '0;
      hold_valid   <= 1'b0;
      hold_q       <= '0;
      host_we_q    <= 1'b0;
      host_addr_q  <= '0;
      host_wdata_q <= '0;
      host_gnt     <= 1'b0;
      host_rvalid  <= 1'b0;
      host_rdata   <= '0;
    end else begin
      host_gnt    <= 1'b0;
      host_rvalid <= 1'b0;
      case (state)
        S_CPU: begin
          hold_valid <= 1'b0;
          if (run_en && (guard_cnt != '0)) begin
            guard_cnt <= guard_cnt - 1'b1;
          end
          if (host_req && ((guard_cnt == '0) || !run_en)) begin
            state        <= S_DRAIN;
            host_we_q    <= host_we;
            host_addr_q  <= host_addr;
            host_wdata_q <= host_wdata;
          end
        end
        S_DRAIN: begin
          hold_q     <= mem_rdata;
          hold_valid <= 1'b1;
          host_gnt   <= 1'b1;
          state      <= S_HOST;
        end
        S_HOST: begin
          if (host_we_q) begin
            state     <= S_CPU;
            guard_cnt <= GUARD_LOAD;
          end else begin
            state <= S_RESP;
          end
        end
        S_RESP: begin
          host_rdata  <= mem_rdata;
          host_rvalid <= 1'b1;
          guard_cnt   <= GUARD_LOAD;
          state       <= S_CPU;
        end
      endcase
    end
  end

  // A stalled CPU may still present a store; gating with run_en keeps it off the RAM.
  always_comb begin
    mem_addr  = cpu_addr;
    mem_wdata = cpu_wdata;
    mem_we    = 1'b0;
    cpu_en    = 1'b0;
    case (state)
      S_CPU: begin
        mem_we = cpu_we & run_en;
        cpu_en = run_en;
      end
      S_DRAIN: begin
        mem_we = 1'b0;
      end
      S_HOST: begin
        mem_addr  = host_addr_q;
        mem_wdata = host_wdata_q;
        mem_we    = host_we_q;
      end
      S_RESP: begin
        mem_addr  = host_addr_q;
        mem_wdata = host_wdata_q;
      end
    endcase
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: a 1-cycle-latency RAM model sits behind
// the arbiter and each scenario task checks its own hand-computed results.
module tb_dmem_arbiter;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 16;
  localparam int GUARD  = 4;

  logic              clock;
  logic              n_rst;
  logic              run_en;
  logic              cpu_en;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_we;
  logic [DATA_W-1:0] cpu_rdata;
  logic              host_req;
  logic              host_we;
  logic [ADDR_W-1:0] host_addr;
  logic [DATA_W-1:0] host_wdata;
  logic              host_gnt;
  logic              host_rvalid;
  logic [DATA_W-1:0] host_rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rdata;

  logic [DATA_W-1:0] ram [0:255];

  int total = 0;
  int bad   = 0;

  dmem_arbiter #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .GUARD (GUARD)
  ) dut (
    .clock      (clock),
    .n_rst      (n_rst),
    .run_en     (run_en),
    .cpu_en     (cpu_en),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_we     (cpu_we),
    .cpu_rdata  (cpu_rdata),
    .host_req   (host_req),
    .host_we    (host_we),
    .host_addr  (host_addr),
    .host_wdata (host_wdata),
    .host_gnt   (host_gnt),
    .host_rvalid(host_rvalid),
    .host_rdata (host_rdata),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_we     (mem_we),
    .mem_rdata  (mem_rdata)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Single-port synchronous RAM, read data one cycle after the address.
  always @(posedge clock) begin
    if (mem_we) ram[mem_addr[7:0]] <= mem_wdata;
    mem_rdata <= ram[mem_addr[7:0]];
  end

  task automatic cycle();
    @(posedge clock);
    #1;
  endtask

  // Drives one host request for a fixed window and records what was observed.
  task automatic host_access(
    input  logic        we,
    input  logic [15:0] addr,
    input  logic [15:0] wdata,
    input  int          cycles,
    output int          low_cnt,
    output int          gnt_cnt,
    output int          gnt_pos,
    output int          rv_cnt,
    output logic [15:0] rv_data,
    output logic [15:0] resume_rdata,
    output logic        resume_rv,
    output logic        gnt_we,
    output logic [15:0] gnt_addr,
    output logic [15:0] gnt_wdata,
    output int          bad_we
  );
    logic resumed;
    logic drop;
    low_cnt = 0; gnt_cnt = 0; gnt_pos = 0; rv_cnt = 0; bad_we = 0;
    rv_data = '0; resume_rdata = '0; resume_rv = 1'b0; resumed = 1'b0;
    gnt_we = 1'b0; gnt_addr = '0; gnt_wdata = '0;
    host_req = 1'b1; host_we = we; host_addr = addr; host_wdata = wdata;
    for (int i = 0; i < cycles; i++) begin
      #1;
      drop = 1'b0;
      if (!cpu_en) low_cnt++;
      else if (low_cnt > 0 && !resumed) begin
        resumed = 1'b1;
        resume_rdata = cpu_rdata;
        resume_rv = host_rvalid;
      end
      if (host_gnt) begin
        gnt_cnt++;
        gnt_pos = low_cnt;
        gnt_we = mem_we;
        gnt_addr = mem_addr;
        gnt_wdata = mem_wdata;
        drop = 1'b1;
      end
      if (host_rvalid) begin
        rv_cnt++;
        rv_data = host_rdata;
      end
      if (mem_we && !cpu_en && !host_gnt) bad_we++;
      cycle();
      if (drop) host_req = 1'b0;
    end
    host_req = 1'b0;
  endtask

  task automatic test_reset();
    n_rst = 1'b1; run_en = 1'b1;
    cpu_addr = 16'h0055; cpu_wdata = 16'h0A0A; cpu_we = 1'b0;
    host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
    #2 n_rst = 1'b0;
    #1;
    total++; if (host_gnt !== 1'b0) begin bad++; $display("[TB] FAIL reset_gnt: got %b expected 0", host_gnt); end
    total++; if (host_rvalid !== 1'b0) begin bad++; $display("[TB] FAIL reset_rvalid: got %b expected 0", host_rvalid); end
    total++; if (host_rdata !== 16'h0000) begin bad++; $display("[TB] FAIL reset_rdata: got %h expected 0000", host_rdata); end
    total++; if (cpu_en !== 1'b1) begin bad++; $display("[TB] FAIL reset_cpu_en: got %b expected 1", cpu_en); end
    total++; if (mem_addr !== 16'h0055) begin bad++; $display("[TB] FAIL reset_mem_addr: got %h expected 0055", mem_addr); end
    total++; if (mem_wdata !== 16'h0A0A) begin bad++; $display("[TB] FAIL reset_mem_wdata: got %h expected 0a0a", mem_wdata); end
    run_en = 1'b0;
    #1;
    total++; if (cpu_en !== 1'b0) begin bad++; $display("[TB] FAIL reset_cpu_en_off: got %b expected 0", cpu_en); end
    run_en = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock) n_rst = 1'b1;
    cycle();
  endtask

  task automatic test_cpu_traffic();
    cpu_addr = 16'h0010; cpu_wdata = 16'h1234; cpu_we = 1'b1;
    #1;
    total++; if (mem_we !== 1'b1) begin bad++; $display("[TB] FAIL cpu_mem_we: got %b expected 1", mem_we); end
    total++; if (mem_addr !== 16'h0010) begin bad++; $display("[TB] FAIL cpu_mem_addr: got %h expected 0010", mem_addr); end
    total++; if (mem_wdata !== 16'h1234) begin bad++; $display("[TB] FAIL cpu_mem_wdata: got %h expected 1234", mem_wdata); end
    cycle();
    cpu_we = 1'b0;
    #1;
    total++; if (mem_we !== 1'b0) begin bad++; $display("[TB] FAIL cpu_mem_we_rd: got %b expected 0", mem_we); end
    cycle();
    #1;
    total++; if (cpu_rdata !== 16'h1234) begin bad++; $display("[TB] FAIL cpu_readback: got %h expected 1234", cpu_rdata); end
    total++; if (cpu_en !== 1'b1) begin bad++; $display("[TB] FAIL cpu_en_idle: got %b expected 1", cpu_en); end
    cycle();
    cpu_we = 1'b1; cpu_addr = 16'h0030; cpu_wdata = 16'h5A5A;
    cycle();
    cpu_addr = 16'h0040; cpu_wdata = 16'h1111;
    cycle();
    cpu_we = 1'b0; cpu_addr = 16'h0000;
    cycle();
    total++; if (ram[8'h30] !== 16'h5A5A) begin bad++; $display("[TB] FAIL cpu_preload: got %h expected 5a5a", ram[8'h30]); end
  endtask

  task automatic test_host_write();
    int low, gnt, pos, rv, bw;
    logic [15:0] rvd, rrd, ga, gd;
    logic rrv, gw;
    host_access(1'b1, 16'h0020, 16'hBEEF, 12, low, gnt, pos, rv, rvd, rrd, rrv, gw, ga, gd, bw);
    total++; if (low !== 2) begin bad++; $display("[TB] FAIL wr_stall: got %0d expected 2", low); end
    total++; if (gnt !== 1) begin bad++; $display("[TB] FAIL wr_gnt_count: got %0d expected 1", gnt); end
    total++; if (pos !== 2) begin bad++; $display("[TB] FAIL wr_gnt_pos: got %0d expected 2", pos); end
    total++; if ({gw, ga, gd} !== {1'b1, 16'h0020, 16'hBEEF}) begin bad++; $display("[TB] FAIL wr_bus: got we=%b a=%h d=%h expected we=1 a=0020 d=beef", gw, ga, gd); end
    total++; if (ram[8'h20] !== 16'hBEEF) begin bad++; $display("[TB] FAIL wr_ram: got %h expected beef", ram[8'h20]); end
    total++; if (rv !== 0) begin bad++; $display("[TB] FAIL wr_rvalid: got %0d expected 0", rv); end
    total++; if (bw !== 0) begin bad++; $display("[TB] FAIL wr_stalled_we: got %0d expected 0", bw); end
  endtask

  task automatic test_host_read_stall();
    int low, gnt, pos, rv, bw;
    logic [15:0] rvd, rrd, ga, gd;
    logic rrv, gw;
    cpu_addr = 16'h0040; cpu_we = 1'b0;
    host_access(1'b0, 16'h0030, 16'h0000, 12, low, gnt, pos, rv, rvd, rrd, rrv, gw, ga, gd, bw);
    total++; if (low !== 3) begin bad++; $display("[TB] FAIL rd_stall: got %0d expected 3", low); end
    total++; if (gnt !== 1 || pos !== 2) begin bad++; $display("[TB] FAIL rd_gnt: got cnt=%0d pos=%0d expected cnt=1 pos=2", gnt, pos); end
    total++; if (rv !== 1) begin bad++; $display("[TB] FAIL rd_rvalid_count: got %0d expected 1", rv); end
    total++; if (rvd !== 16'h5A5A) begin bad++; $display("[TB] FAIL rd_data: got %h expected 5a5a", rvd); end
    total++; if (rrv !== 1'b1) begin bad++; $display("[TB] FAIL rd_rvalid_pos: got %b expected 1", rrv); end
    total++; if (rrd !== 16'h1111) begin bad++; $display("[TB] FAIL rd_cpu_hold: got %h expected 1111", rrd); end
    total++; if (host_rdata !== 16'h5A5A) begin bad++; $display("[TB] FAIL rd_data_hold: got %h expected 5a5a", host_rdata); end
    cpu_addr = 16'h0000;
  endtask

  task automatic test_guard();
    int gnts, en_since, min_between, first_g, gap, en_high;
    gnts = 0; en_since = 0; min_between = 1000;
    run_en = 1'b1;
    host_req = 1'b1; host_we = 1'b1; host_addr = 16'h0050; host_wdata = 16'h7777;
    for (int i = 0; i < 30; i++) begin
      #1;
      if (host_gnt) begin
        if (gnts > 0 && en_since < min_between) min_between = en_since;
        gnts++;
        en_since = 0;
      end else if (cpu_en) en_since++;
      cycle();
    end
    host_req = 1'b0;
    total++; if (gnts < 3) begin bad++; $display("[TB] FAIL guard_gnts: got %0d expected >=3", gnts); end
    total++; if (min_between < GUARD) begin bad++; $display("[TB] FAIL guard_spacing: got %0d expected >=%0d", min_between, GUARD); end
    repeat (10) cycle();
    // With run_en low the guard must not delay the next grant.
    run_en = 1'b0; host_req = 1'b1;
    gnts = 0; first_g = -1; gap = -1; en_high = 0;
    for (int i = 0; i < 12; i++) begin
      #1;
      if (cpu_en) en_high++;
      if (host_gnt) begin
        if (gnts == 0) first_g = i;
        else if (gnts == 1) gap = i - first_g;
        gnts++;
      end
      cycle();
    end
    host_req = 1'b0; run_en = 1'b1;
    total++; if (gap !== 3) begin bad++; $display("[TB] FAIL guard_runoff_gap: got %0d expected 3", gap); end
    total++; if (en_high !== 0) begin bad++; $display("[TB] FAIL guard_runoff_en: got %0d expected 0", en_high); end
    repeat (10) cycle();
  endtask

  task automatic test_reset_in_host();
    int low, gnt, pos, rv, bw;
    logic [15:0] rvd, rrd, ga, gd;
    logic rrv, gw;
    logic seen;
    int rv_in_reset;
    seen = 1'b0; rv_in_reset = 0;
    host_req = 1'b1; host_we = 1'b0; host_addr = 16'h0030;
    for (int i = 0; i < 6; i++) begin
      #1;
      if (host_gnt) begin seen = 1'b1; break; end
      cycle();
    end
    total++; if (seen !== 1'b1) begin bad++; $display("[TB] FAIL rst_host_gnt_timeout: got %b expected 1", seen); end
    n_rst = 1'b0; host_req = 1'b0;
    #1;
    total++; if (host_gnt !== 1'b0) begin bad++; $display("[TB] FAIL rst_host_gnt: got %b expected 0", host_gnt); end
    total++; if (cpu_en !== 1'b1) begin bad++; $display("[TB] FAIL rst_host_cpu_en: got %b expected 1", cpu_en); end
    total++; if (host_rdata !== 16'h0000) begin bad++; $display("[TB] FAIL rst_host_rdata: got %h expected 0000", host_rdata); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      if (host_rvalid) rv_in_reset++;
    end
    n_rst = 1'b1;
    cycle();
    total++; if (rv_in_reset !== 0 || host_rvalid !== 1'b0) begin bad++; $display("[TB] FAIL rst_host_rvalid: got %0d/%b expected 0/0", rv_in_reset, host_rvalid); end
    host_access(1'b0, 16'h0030, 16'h0000, 12, low, gnt, pos, rv, rvd, rrd, rrv, gw, ga, gd, bw);
    total++; if (gnt !== 1 || low !== 3) begin bad++; $display("[TB] FAIL rst_rereq_gnt: got gnt=%0d low=%0d expected gnt=1 low=3", gnt, low); end
    total++; if (rv !== 1 || rvd !== 16'h5A5A) begin bad++; $display("[TB] FAIL rst_rereq_data: got rv=%0d d=%h expected rv=1 d=5a5a", rv, rvd); end
  endtask

  initial begin
    test_reset();
    test_cpu_traffic();
    test_host_write();
    test_host_read_stall();
    test_guard();
    test_reset_in_host();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
